// File: rtl/fa_sync_event_gen_pkg.sv
`default_nettype none
// ==========================================================================
// fa_sync_event_gen_pkg : shared FA/heartbeat timing constants and types
// Revision: 1.0
// ==========================================================================
package fa_sync_event_gen_pkg;

    localparam int unsigned SYS_CLK_HZ               = 124_640_000;
    localparam int unsigned FA_DIVISOR_DEFAULT       = 12464;
    localparam int unsigned HEARTBEAT_DIVIDE_DEFAULT = 10000;

    // Shared with the EVR-side decoder, so both ends agree on the marker code.
    localparam logic [7:0]  EVCODE_HEARTBEAT         = 8'h7A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_HB = 2'd1,
        ST_SEND_SW = 2'd2
    } ev_state_t;

    function automatic int cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fa_sync_event_gen_pps_edge_sync.sv
`default_nettype none
// ==========================================================================
// pps_edge_sync : multi-flop synchroniser for PPS plus rising-edge pulse
// Revision: 1.0
// ==========================================================================
module pps_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pps_async,
    output logic pps_rise
);

    // chain[STAGES-1] is the last synchroniser flop, chain[STAGES] its previous value.
    logic [STAGES:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-1:0], pps_async};
        end
    end

    assign pps_rise = chain[STAGES-1] & ~chain[STAGES];

endmodule
`default_nettype wire

// File: rtl/fa_sync_event_gen.sv
`default_nettype none
// ==========================================================================
// fa_sync_event_gen : FA period / heartbeat event source with PPS alignment
//                     and software event merge onto a valid/ready byte link
// Revision: 1.0
// ==========================================================================
module fa_sync_event_gen #(
    parameter int unsigned FA_DIVISOR       = fa_sync_event_gen_pkg::FA_DIVISOR_DEFAULT,
    parameter int unsigned HEARTBEAT_DIVIDE = fa_sync_event_gen_pkg::HEARTBEAT_DIVIDE_DEFAULT,
    parameter logic [7:0]  EVCODE_HEARTBEAT = fa_sync_event_gen_pkg::EVCODE_HEARTBEAT,
    parameter int unsigned PPS_SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ppsAlignEnable,
    input  logic       ppsIn,
    input  logic       swEventValid,
    input  logic [7:0] swEventCode,
    output logic       swEventReady,
    output logic [7:0] evCode,
    output logic       evValid,
    input  logic       evReady,
    output logic       faTick,
    output logic       heartbeatTick,
    output logic       ppsAligned,
    output logic       overrun,
    input  logic       overrunClear
);
    import fa_sync_event_gen_pkg::*;

    localparam int FA_W = cnt_width(FA_DIVISOR);
    localparam int HB_W = cnt_width(HEARTBEAT_DIVIDE);
    localparam logic [FA_W-1:0] FA_RELOAD = FA_W'(FA_DIVISOR - 1);
    localparam logic [HB_W-1:0] HB_RELOAD = HB_W'(HEARTBEAT_DIVIDE - 1);

    logic [FA_W-1:0] fa_count;
    logic [HB_W-1:0] hb_count;
    logic            fa_tick;
    logic            hb_tick;
    logic            pps_aligned;
    logic            pps_rise;

    logic            fa_term;
    logic            hb_term;
    logic            align_now;
    logic            hb_fire;

    ev_state_t       state;
    ev_state_t       state_nxt;
    logic [7:0]      code_q;
    logic [7:0]      code_nxt;
    logic            hb_pending;
    logic            hb_pending_nxt;
    logic            overrun_q;
    logic            overrun_nxt;
    logic            hb_take;
    logic            hb_busy;
    logic            sw_ready;

    pps_edge_sync #(
        .STAGES    (PPS_SYNC_STAGES)
    ) u_pps_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pps_async (ppsIn),
        .pps_rise  (pps_rise)
    );

    assign fa_term   = (fa_count == '0);
    assign hb_term   = (hb_count == '0);
    assign align_now = enable && pps_rise && ppsAlignEnable;
    // An alignment edge on the natural terminal count still fires only once.
    assign hb_fire   = align_now || (enable && fa_term && hb_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_count    <= FA_RELOAD;
            hb_count    <= HB_RELOAD;
            fa_tick     <= 1'b0;
            hb_tick     <= 1'b0;
            pps_aligned <= 1'b0;
        end else begin
            fa_tick <= 1'b0;
            hb_tick <= hb_fire;
            if (pps_rise) begin
                pps_aligned <= fa_term && hb_term;
            end
            if (!enable) begin
                fa_count <= FA_RELOAD;
                hb_count <= HB_RELOAD;
            end else if (align_now) begin
                // A realign starts a fresh FA period, so it is an FA boundary too.
                fa_count <= FA_RELOAD;
                hb_count <= HB_RELOAD;
                fa_tick  <= 1'b1;
            end else if (fa_term) begin
                fa_count <= FA_RELOAD;
                fa_tick  <= 1'b1;
                hb_count <= hb_term ? HB_RELOAD : hb_count - 1'b1;
            end else begin
                fa_count <= fa_count - 1'b1;
            end
        end
    end

    // A heartbeat is still outstanding while queued or being offered but not yet taken.
    assign hb_busy = hb_pending || ((state == ST_SEND_HB) && !evReady);

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        sw_ready  = 1'b0;
        hb_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hb_pending) begin
                    state_nxt = ST_SEND_HB;
                    code_nxt  = EVCODE_HEARTBEAT;
                    hb_take   = 1'b1;
                end else if (swEventValid) begin
                    sw_ready = 1'b1;
                    if (swEventCode != 8'h00) begin
                        state_nxt = ST_SEND_SW;
                        code_nxt  = swEventCode;
                    end
                end
            end
            ST_SEND_HB, ST_SEND_SW: begin
                if (evReady) begin
                    state_nxt = ST_IDLE;
                    code_nxt  = 8'h00;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                code_nxt  = 8'h00;
            end
        endcase
    end

    always_comb begin
        hb_pending_nxt = hb_pending;
        overrun_nxt    = overrun_q;
        if (hb_fire && !hb_busy) begin
            hb_pending_nxt = 1'b1;
        end else if (hb_take) begin
            hb_pending_nxt = 1'b0;
        end
        if (hb_fire && hb_busy) begin
            overrun_nxt = 1'b1;
        end else if (overrunClear) begin
            overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            code_q     <= 8'h00;
            hb_pending <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            code_q     <= code_nxt;
            hb_pending <= hb_pending_nxt;
            overrun_q  <= overrun_nxt;
        end
    end

    assign swEventReady  = sw_ready;
    assign evValid       = (state != ST_IDLE);
    assign evCode        = code_q;
    assign faTick        = fa_tick;
    assign heartbeatTick = hb_tick;
    assign ppsAligned    = pps_aligned;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fa_sync_event_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_fa_sync_event_gen : scoreboard bench, FA_DIVISOR=8, HEARTBEAT_DIVIDE=4
// Revision: 1.0
// ==========================================================================
module tb_fa_sync_event_gen;

    localparam int         FA  = 8;
    localparam int         HB  = 4;
    localparam int         PER = FA * HB;
    localparam logic [7:0] HBC = 8'h7A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       ppsAlignEnable = 1'b0;
    logic       ppsIn = 1'b0;
    logic       swEventValid = 1'b0;
    logic [7:0] swEventCode = 8'h00;
    logic       evReady = 1'b0;
    logic       overrunClear = 1'b0;
    logic       swEventReady;
    logic [7:0] evCode;
    logic       evValid;
    logic       faTick;
    logic       heartbeatTick;
    logic       ppsAligned;
    logic       overrun;

    always #5 clk = ~clk;

    fa_sync_event_gen #(
        .FA_DIVISOR       (FA),
        .HEARTBEAT_DIVIDE (HB),
        .EVCODE_HEARTBEAT (HBC),
        .PPS_SYNC_STAGES  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .ppsAlignEnable (ppsAlignEnable),
        .ppsIn          (ppsIn),
        .swEventValid   (swEventValid),
        .swEventCode    (swEventCode),
        .swEventReady   (swEventReady),
        .evCode         (evCode),
        .evValid        (evValid),
        .evReady        (evReady),
        .faTick         (faTick),
        .heartbeatTick  (heartbeatTick),
        .ppsAligned     (ppsAligned),
        .overrun        (overrun),
        .overrunClear   (overrunClear)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phase = enabled clocks since the last reload (0..PER-1).
    int         m_ph;
    bit         m_fa, m_hb, m_al, m_ov;
    bit [1:0]   m_pipe;
    bit         m_prev_pps;
    int         m_hb_out;
    logic [7:0] sbq[$];

    int         cyc, fa_cnt, hb_cnt, sw_rdy_cnt, hb_xfer_cnt;
    int         last_hb_xfer_cyc, last_sw_rdy_cyc;
    logic       prev_v, prev_r;
    logic [7:0] prev_code;

    always @(negedge clk) begin
        bit         eff, rise, fire;
        logic [7:0] exp_code;
        if (!rst_n) begin
            m_ph = 0; m_fa = 0; m_hb = 0; m_al = 0; m_ov = 0;
            m_pipe = '0; m_prev_pps = 0; m_hb_out = 0;
            sbq.delete();
            prev_v = 0; prev_r = 0; prev_code = '0;
        end else begin
            cyc++;
            chk("faTick", faTick, m_fa);
            chk("heartbeatTick", heartbeatTick, m_hb);
            chk("ppsAligned", ppsAligned, m_al);
            chk("overrun", overrun, m_ov);
            if (prev_v && !prev_r) begin
                chk("evValid_hold", evValid, 1);
                chk("evCode_hold", evCode, prev_code);
            end
            if (faTick) fa_cnt++;
            if (heartbeatTick) hb_cnt++;
            if (evValid && evReady) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard: got code 0x%0h, want no transfer", evCode);
                end else begin
                    exp_code = sbq.pop_front();
                    chk("scoreboard_code", evCode, exp_code);
                    if (exp_code == HBC) begin
                        m_hb_out--;
                        hb_xfer_cnt++;
                        last_hb_xfer_cyc = cyc;
                    end
                end
            end
            if (swEventValid && swEventReady) begin
                sw_rdy_cnt++;
                last_sw_rdy_cyc = cyc;
                if (swEventCode != 8'h00) sbq.push_back(swEventCode);
            end

            // Predict what the next clock edge produces.
            eff        = m_pipe[1];
            rise       = ppsIn && !m_prev_pps;
            m_pipe     = {m_pipe[0], rise};
            m_prev_pps = ppsIn;
            fire = 0;
            m_fa = 0;
            if (eff) m_al = (m_ph == PER - 1);
            if (!enable) begin
                m_ph = 0;
            end else if (eff && ppsAlignEnable) begin
                fire = 1; m_fa = 1; m_ph = 0;
            end else begin
                if (m_ph % FA == FA - 1) m_fa = 1;
                if (m_ph == PER - 1) fire = 1;
                m_ph = (m_ph + 1) % PER;
            end
            m_hb = fire;
            if (fire) begin
                if (m_hb_out > 0) m_ov = 1;
                else begin
                    m_hb_out++;
                    sbq.push_back(HBC);
                end
            end else if (overrunClear) begin
                m_ov = 0;
            end
            prev_v = evValid; prev_r = evReady; prev_code = evCode;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at the falling edge where heartbeatTick is seen; cycles = falling edges waited.
    task automatic wait_hb(input int lim, output int cycles);
        cycles = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (heartbeatTick) begin
                cycles = i + 1;
                break;
            end
        end
        if (cycles < 0) begin
            total++; bad++;
            $display("FAIL wait_hb: got no heartbeatTick in %0d cycles, want one", lim);
        end
    endtask

    task automatic wait_ph(input int ph);
        for (int i = 0; i < 2 * PER && m_ph != ph; i++) tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1);
    end

    initial begin
        int  n, c0, h0, x0, s0;
        bit  hs;
        tick(3);
        @(negedge clk);
        chk("reset_evValid", evValid, 0);
        chk("reset_evCode", evCode, 0);
        chk("reset_faTick", faTick, 0);
        chk("reset_heartbeatTick", heartbeatTick, 0);
        chk("reset_ppsAligned", ppsAligned, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_swEventReady", swEventReady, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b1; evReady = 1'b1;

        // Free run: heartbeat code one cycle after heartbeatTick, one cycle wide.
        wait_hb(40, n);
        @(negedge clk);
        chk("hb_latency_valid", evValid, 1);
        chk("hb_latency_code", evCode, HBC);
        @(negedge clk);
        chk("hb_single_cycle", evValid, 0);
        tick(1);
        c0 = fa_cnt; h0 = hb_cnt; x0 = hb_xfer_cnt;
        tick(64);
        chk("fa_per_64", fa_cnt - c0, 8);
        chk("hb_per_64", hb_cnt - h0, 2);
        chk("hb_xfer_per_64", hb_xfer_cnt - x0, 2);

        // Stalled transmitter: second heartbeat is dropped and flagged.
        wait_hb(40, n);
        #1 evReady = 1'b0;
        tick(40);
        chk("stall_overrun", overrun, 1);
        chk("stall_valid", evValid, 1);
        x0 = hb_xfer_cnt;
        evReady = 1'b1;
        tick(10);
        chk("stall_one_xfer", hb_xfer_cnt - x0, 1);
        overrunClear = 1'b1;
        tick(1);
        overrunClear = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Software request in the same cycle as a heartbeat waits behind it.
        wait_hb(40, n);
        #1;
        s0 = sw_rdy_cnt;
        swEventValid = 1'b1; swEventCode = 8'h21;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hs = swEventReady;
            tick(1);
            if (hs) break;
        end
        swEventValid = 1'b0;
        tick(5);
        chk("sw_ready_once", sw_rdy_cnt - s0, 1);
        chk("sw_after_hb_xfer", (last_sw_rdy_cyc > last_hb_xfer_cyc), 1);

        // PPS mid-period (realign lands where faCount=3): sampled edge + 2 synchroniser clocks.
        ppsAlignEnable = 1'b1;
        wait_ph(2);
        ppsIn = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (heartbeatTick) begin
                n = i;
                break;
            end
        end
        chk("pps_hb_delay", n, 3);
        chk("pps_mid_aligned", ppsAligned, 0);
        #1 ppsIn = 1'b0;
        wait_hb(40, n);
        chk("pps_next_hb_period", n, 32);

        // PPS landing exactly on the terminal count.
        tick(1);
        wait_ph(PER - 3);
        h0 = hb_cnt;
        ppsIn = 1'b1;
        tick(6);
        chk("pps_term_single_hb", hb_cnt - h0, 1);
        chk("pps_term_aligned", ppsAligned, 1);
        ppsIn = 1'b0;

        // Asynchronous reset while a transfer is being offered.
        evReady = 1'b0;
        wait_hb(40, n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_evValid", evValid, 0);
        chk("rst_mid_evCode", evCode, 0);
        chk("rst_mid_heartbeatTick", heartbeatTick, 0);
        chk("rst_mid_faTick", faTick, 0);
        chk("rst_mid_overrun", overrun, 0);
        evReady = 1'b1;
        tick(2);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (faTick) begin
                n = i;
                break;
            end
        end
        chk("post_reset_first_fa", n, 8);
        tick(1);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hs = swEventValid && swEventReady;
            tick(1);
            evReady        = ($urandom_range(0, 3) != 0);
            enable         = ($urandom_range(0, 299) != 0);
            overrunClear   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) ppsAlignEnable = ~ppsAlignEnable;
            if ($urandom_range(0, 39) == 0) ppsIn = ~ppsIn;
            if (hs) begin
                swEventValid = 1'b0;
            end else if (!swEventValid && $urandom_range(0, 7) == 0) begin
                swEventValid = 1'b1;
                swEventCode  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                if (swEventCode == HBC) swEventCode = 8'h7B;
            end
        end

        enable = 1'b0; swEventValid = 1'b0; evReady = 1'b1; overrunClear = 1'b0;
        tick(12);
        chk("drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fa_sync_event_gen.md
Name: fa_sync_event_gen

Overview:
Event-side source of the FA/heartbeat timing that EVR-side FA marker logic locks onto. The block divides the system clock into FA periods and emits a heartbeat event code every HEARTBEAT_DIVIDE FA periods. It optionally phase-aligns to an external PPS and merges software-injected event codes. Output goes to the event-link transmitter over a valid/ready byte interface.

Parameters:
FA_DIVISOR, 12464, clocks per FA period (152*328/4)
HEARTBEAT_DIVIDE, 10000, FA periods per heartbeat event (1 s at 124.64 MHz)
EVCODE_HEARTBEAT, 8'h7A, event code sent on each heartbeat
PPS_SYNC_STAGES, 2, synchroniser depth for ppsIn

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run counters and issue heartbeats
ppsAlignEnable  in  1  allow ppsIn rising edge to realign counters
ppsIn  in  1  asynchronous PPS input
swEventValid  in  1  software event request
swEventCode  in  8  software event code (0x00 is never sent)
swEventReady  out  1  software event accepted this cycle
evCode  out  8  event code to transmitter
evValid  out  1  evCode valid
evReady  in  1  transmitter accepts evCode
faTick  out  1  one-cycle pulse at each FA period boundary
heartbeatTick  out  1  one-cycle pulse when a heartbeat is requested
ppsAligned  out  1  last PPS edge found counters already in phase
overrun  out  1  sticky: heartbeat dropped because the previous one was still pending
overrunClear  in  1  clears overrun

Behaviour:
- Reset: all outputs 0. faCount = FA_DIVISOR-1. hbCount = HEARTBEAT_DIVIDE-1. State IDLE. hbPending = 0. PPS synchroniser cleared.
- faCount decrements every cycle while enable=1. At 0: reload FA_DIVISOR-1, faTick=1 for one cycle, hbCount decrements.
- When hbCount=0 and faCount=0: reload hbCount, heartbeatTick=1, set hbPending.
- enable=0: both counters held at reload values; no ticks. An in-flight evValid transaction still completes.
- PPS: ppsIn passes through PPS_SYNC_STAGES flops, then a rising-edge detect.
  - On an edge with ppsAlignEnable=1 and enable=1: counters reload and heartbeatTick/hbPending assert in the same cycle.
  - ppsAligned is set to (faCount==0 && hbCount==0) at that edge; otherwise it is cleared.
  - An edge coinciding with the natural terminal count yields exactly one heartbeat.
  - With ppsAlignEnable=0, edges only update ppsAligned.
- Output FSM, states IDLE, SEND_HB, SEND_SW:
  - IDLE: if hbPending, go to SEND_HB, set evCode=EVCODE_HEARTBEAT, evValid=1, clear hbPending.
  - Otherwise, if swEventValid && swEventCode!=0: swEventReady=1 for one cycle, latch the code, go to SEND_SW, evValid=1.
  - A zero swEventCode is accepted (swEventReady=1) and discarded.
  - SEND_*: evValid and evCode are held stable until evValid && evReady, then return to IDLE with evValid=0 the following cycle. Back-to-back transfers need one IDLE cycle.
- Priority: heartbeat over software. A software request waits while a heartbeat is pending.
- Latency: heartbeatTick at cycle t gives evValid=1 at t+1 when IDLE, and evValid stays 1 until evReady is seen.
- Collision: a new heartbeat while hbPending=1 leaves hbPending set and sets overrun. overrunClear in the same cycle loses to the set.
- Reset mid-transfer: evValid drops immediately (asynchronous). The transmitter must tolerate this.

Decomposition:
- Shared timing package holds:
  - FA_DIVISOR_DEFAULT and the 124.64 MHz clock constant.
  - EVCODE_HEARTBEAT, also used by EVR-side decode.
  - Output FSM state enum.
- One sub-module: pps_edge_sync (PPS_SYNC_STAGES-flop synchroniser plus rising-edge pulse).

Test Plan:
(Use FA_DIVISOR=8, HEARTBEAT_DIVIDE=4 throughout.)
- Free run, evReady=1 → faTick every 8 clocks; heartbeatTick every 32 clocks; evCode=0x7A with evValid high for exactly 1 cycle, one cycle after each heartbeatTick.
- Hold evReady=0 for 40 clocks → evValid/evCode stable; the second heartbeat sets overrun=1; after evReady, exactly one 0x7A is transferred; overrunClear clears overrun.
- swEventValid with code 0x21, simultaneous with heartbeatTick → 0x7A is sent first, then 0x21; swEventReady pulses once, no earlier than the cycle after the 0x7A transfer.
- PPS edge injected mid-period at faCount=3 → ppsAligned=0; heartbeatTick 2 clocks after the edge (synchroniser); next heartbeat 32 clocks later.
- PPS edge landing exactly on the terminal count → ppsAligned=1; a single heartbeat, no duplicate.
- Assert rst_n low while evValid=1 → all outputs 0 immediately; after release, first faTick 8 clocks later.
